// File: rtl/regfile_fwd_sb.sv
// Register file with HI/LO, N-port forwarding network and a
// long-latency pending-write scoreboard driving per-port stalls.
module regfile_fwd_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NSTAGE = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rstall,
  input  logic [NSTAGE-1:0]        stg_we,
  input  logic [NSTAGE-1:0]        stg_rdy,
  input  logic [NSTAGE*ADDR_W-1:0] stg_waddr,
  input  logic [NSTAGE*DATA_W-1:0] stg_wdata,
  input  logic [NSTAGE-1:0]        stg_hi_we,
  input  logic [NSTAGE-1:0]        stg_lo_we,
  input  logic [NSTAGE*DATA_W-1:0] stg_hi_wdata,
  input  logic [NSTAGE*DATA_W-1:0] stg_lo_wdata,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     hi_we,
  input  logic                     lo_we,
  input  logic [DATA_W-1:0]        hi_wdata,
  input  logic [DATA_W-1:0]        lo_wdata,
  input  logic                     lt_issue,
  input  logic [ADDR_W-1:0]        lt_waddr,
  input  logic                     lt_hilo_issue,
  input  logic                     lt_wb,
  input  logic                     flush,
  output logic [DATA_W-1:0]        hi_rdata,
  output logic [DATA_W-1:0]        lo_rdata,
  output logic                     hilo_stall
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_gpr [NREG];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [NREG-1:0]   r_busy;
  logic              r_hilo_busy;
  logic              w_hilo_wr;

  // GPR array; entry 0 is never written so it reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_gpr[k] <= '0;
    end else if (we && waddr != '0) begin
      r_gpr[waddr] <= wdata;
    end
  end

  // HI/LO pair, written independently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (hi_we) r_hi <= hi_wdata;
      if (lo_we) r_lo <= lo_wdata;
    end
  end

  // GPR scoreboard: flush wins over everything, a new issue wins over a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (we && lt_wb) r_busy[waddr] <= 1'b0;
      if (lt_issue && lt_waddr != '0) r_busy[lt_waddr] <= 1'b1;
    end
  end

  // HI/LO scoreboard bit with the same priorities
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hilo_busy <= 1'b0;
    end else if (flush) begin
      r_hilo_busy <= 1'b0;
    end else if (lt_hilo_issue) begin
      r_hilo_busy <= 1'b1;
    end else if ((hi_we || lo_we) && lt_wb) begin
      r_hilo_busy <= 1'b0;
    end
  end

  // Read ports: array/commit first, then stages oldest to youngest override
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              s;
    rdata  = '0;
    rstall = '0;
    a = '0;
    d = '0;
    s = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      a = raddr[i*ADDR_W +: ADDR_W];
      if (we && waddr == a) begin
        d = wdata;
        s = 1'b0;
      end else begin
        d = r_gpr[a];
        s = r_busy[a];
      end
      for (int j = NSTAGE - 1; j >= 0; j--) begin
        if (stg_we[j] && stg_waddr[j*ADDR_W +: ADDR_W] == a) begin
          d = stg_wdata[j*DATA_W +: DATA_W];
          s = ~stg_rdy[j];
        end
      end
      if (a == '0) begin
        d = '0;
        s = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = d;
      rstall[i] = s;
    end
  end

  // HI/LO read: youngest stage, then commit, then register
  always_comb begin
    hi_rdata = hi_we ? hi_wdata : r_hi;
    lo_rdata = lo_we ? lo_wdata : r_lo;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      if (stg_hi_we[j]) hi_rdata = stg_hi_wdata[j*DATA_W +: DATA_W];
      if (stg_lo_we[j]) lo_rdata = stg_lo_wdata[j*DATA_W +: DATA_W];
    end
  end

  // Any in-flight HI/LO write this cycle lets the consumer proceed
  always_comb begin
    w_hilo_wr  = (|stg_hi_we) | (|stg_lo_we) | hi_we | lo_we;
    hilo_stall = r_hilo_busy & ~w_hilo_wr;
  end

endmodule
